// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the EXE-stage multiply/divide sequencer:
// state encoding, default multiplier latency and divider dout slice offsets.
package muldiv_ctrl_pkg;

   localparam int MUL_LAT_DEF = 2;

   // Field offsets inside the divider m_axis_dout_tdata word
   localparam int QUOT_LSB = 40;
   localparam int REM_LSB  = 0;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_MUL_WAIT  = 3'd1;
   localparam logic [2:0] ST_DIV_ISSUE = 3'd2;
   localparam logic [2:0] ST_DIV_WAIT  = 3'd3;
   localparam logic [2:0] ST_DONE      = 3'd4;
   localparam logic [2:0] ST_DIV_DRAIN = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE      = ST_IDLE,
      S_MUL_WAIT  = ST_MUL_WAIT,
      S_DIV_ISSUE = ST_DIV_ISSUE,
      S_DIV_WAIT  = ST_DIV_WAIT,
      S_DONE      = ST_DONE,
      S_DIV_DRAIN = ST_DIV_DRAIN
   } state_t;

   function automatic logic [32:0] ext33(input logic uns, input logic [31:0] x);
      return uns ? {1'b0, x} : {x[31], x};
   endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Bundle between the EXE stage / multiplier / divider IP (master) and the
// muldiv sequencer (slave).
// Handshake: the sequencer starts an op when exe_valid & (mul_req|div_req) & ~flush
// in IDLE; done stays high until the cycle exe_ack is seen; div_tvalid is a
// one-cycle pulse and div_dout_valid is accepted in whatever cycle it arrives.
interface muldiv_ctrl_if;
   logic        exe_valid;
   logic        mul_req;
   logic        div_req;
   logic        unsigned_op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        exe_ack;
   logic        flush;
   logic [32:0] mul_a;
   logic [32:0] mul_b;
   logic [65:0] mul_p;
   logic [32:0] div_dividend;
   logic [32:0] div_divisor;
   logic        div_tvalid;
   logic        div_dout_valid;
   logic [31:0] div_quot;
   logic [31:0] div_rem;
   logic        busy;
   logic        done;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   modport master (
      output exe_valid, mul_req, div_req, unsigned_op, op_a, op_b, exe_ack, flush,
             mul_p, div_dout_valid, div_quot, div_rem,
      input  mul_a, mul_b, div_dividend, div_divisor, div_tvalid, busy, done,
             hi_out, lo_out
   );

   modport slave (
      input  exe_valid, mul_req, div_req, unsigned_op, op_a, op_b, exe_ack, flush,
             mul_p, div_dout_valid, div_quot, div_rem,
      output mul_a, mul_b, div_dividend, div_divisor, div_tvalid, busy, done,
             hi_out, lo_out
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencer for the EXE-stage multiplier and divider IP cores: latches operands,
// waits out the multiplier latency or the divider handshake, and holds HI/LO until EXE advances.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_ctrl_if.slave bus,
   output state_t       dbg_state
);

   localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt;
   logic             load_mul, load_div, cap_mul, cap_div;

   logic [32:0] mul_a_q, mul_b_q, dividend_q, divisor_q;
   logic [31:0] hi_q, lo_q;

   always_comb begin
      state_n  = state;
      load_mul = 1'b0;
      load_div = 1'b0;
      cap_mul  = 1'b0;
      cap_div  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.exe_valid && !bus.flush) begin
               if (bus.mul_req) begin
                  load_mul = 1'b1;
                  state_n  = S_MUL_WAIT;
               end else if (bus.div_req) begin
                  load_div = 1'b1;
                  state_n  = S_DIV_ISSUE;
               end
            end
         end
         S_MUL_WAIT: begin
            if (bus.flush) begin
               state_n = S_IDLE;
            end else if (cnt == '0) begin
               cap_mul = 1'b1;
               state_n = S_DONE;
            end
         end
         // The pulse goes out even under flush: the divider has no cancel input
         S_DIV_ISSUE: state_n = bus.flush ? S_DIV_DRAIN : S_DIV_WAIT;
         S_DIV_WAIT: begin
            if (bus.div_dout_valid) begin
               if (bus.flush) begin
                  state_n = S_IDLE;
               end else begin
                  cap_div = 1'b1;
                  state_n = S_DONE;
               end
            end else if (bus.flush) begin
               state_n = S_DIV_DRAIN;
            end
         end
         S_DONE: begin
            if (bus.flush || bus.exe_ack) state_n = S_IDLE;
         end
         S_DIV_DRAIN: begin
            if (bus.div_dout_valid) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load_mul) begin
         cnt <= CNT_W'(MUL_LAT - 1);
      end else if (state == S_MUL_WAIT && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mul_a_q    <= '0;
         mul_b_q    <= '0;
         dividend_q <= '0;
         divisor_q  <= '0;
      end else begin
         if (load_mul) begin
            mul_a_q <= ext33(bus.unsigned_op, bus.op_a);
            mul_b_q <= ext33(bus.unsigned_op, bus.op_b);
         end
         if (load_div) begin
            dividend_q <= ext33(bus.unsigned_op, bus.op_a);
            divisor_q  <= ext33(bus.unsigned_op, bus.op_b);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (cap_mul) begin
         hi_q <= bus.mul_p[63:32];
         lo_q <= bus.mul_p[31:0];
      end else if (cap_div) begin
         hi_q <= bus.div_rem;
         lo_q <= bus.div_quot;
      end
   end

   assign bus.mul_a        = mul_a_q;
   assign bus.mul_b        = mul_b_q;
   assign bus.div_dividend = dividend_q;
   assign bus.div_divisor  = divisor_q;
   assign bus.hi_out       = hi_q;
   assign bus.lo_out       = lo_q;
   assign bus.div_tvalid   = (state == S_DIV_ISSUE);
   assign bus.busy         = (state != S_IDLE);
   assign bus.done         = (state == S_DONE) && !bus.flush;
   assign dbg_state        = state;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural multiplier/divider IP models, an
// arithmetic reference for HI/LO, directed scenarios and randomized ops.
module tb_muldiv_ctrl;
   import muldiv_ctrl_pkg::*;

   localparam int MUL_LAT = MUL_LAT_DEF;

   logic   clk = 1'b0;
   logic   reset;
   state_t dbg_state;

   muldiv_ctrl_if bus();

   muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int check_cnt = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Multiplier IP: signed 66-bit product of the registered operands
   assign bus.mul_p = {{33{bus.mul_a[32]}}, bus.mul_a} * {{33{bus.mul_b[32]}}, bus.mul_b};

   // Divider IP: fixed latency per issue, not affected by reset
   int          div_lat = 4;
   int          ip_cd = 0;
   int          tv_cyc = -1;
   int          dv_cyc = -1;
   int          tvalid_cnt = 0;
   logic [71:0] ip_dout = '0;

   assign bus.div_quot = ip_dout[QUOT_LSB +: 32];
   assign bus.div_rem  = ip_dout[REM_LSB +: 32];

   always @(negedge clk) begin
      longint nd, nv;
      bus.div_dout_valid = 1'b0;
      if (ip_cd > 0) begin
         ip_cd--;
         if (ip_cd == 0) begin
            bus.div_dout_valid = 1'b1;
            dv_cyc = cyc;
         end
      end
      if (bus.div_tvalid === 1'b1) begin
         tvalid_cnt++;
         tv_cyc = cyc;
         nd = longint'($signed(bus.div_dividend));
         nv = longint'($signed(bus.div_divisor));
         ip_dout = '0;
         if (nv != 0) begin
            ip_dout[QUOT_LSB +: 32] = 32'(nd / nv);
            ip_dout[REM_LSB +: 32]  = 32'(nd % nv);
         end
         ip_cd = div_lat;
      end
   end

   function automatic logic [63:0] ref_result(input bit is_div, input bit uns,
                                               input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, m;
      if (uns) begin
         sa = longint'(a);
         sb = longint'(b);
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end
      if (!is_div) return 64'(sa * sb);
      q = sa / sb;
      m = sa % sb;
      return {32'(m), 32'(q)};
   endfunction

   task automatic drive_op(input bit is_div, input bit uns, input logic [31:0] a,
                           input logic [31:0] b);
      bus.exe_valid   = 1'b1;
      bus.mul_req     = !is_div;
      bus.div_req     = is_div;
      bus.unsigned_op = uns;
      bus.op_a        = a;
      bus.op_b        = b;
   endtask

   task automatic clear_req;
      bus.exe_valid = 1'b0;
      bus.mul_req   = 1'b0;
      bus.div_req   = 1'b0;
   endtask

   // Present an op at the current negedge; return the negedge count until done
   task automatic run_op(input bit is_div, input bit uns, input logic [31:0] a,
                         input logic [31:0] b, output int lat);
      drive_op(is_div, uns, a, b);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (bus.done !== 1'b1 && lat < 400);
   endtask

   task automatic ack_op;
      bus.exe_ack = 1'b1;
      @(negedge clk);
      bus.exe_ack = 1'b0;
      clear_req();
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic test_reset;
      check_cnt++;
      if ({bus.mul_a, bus.mul_b, bus.div_dividend, bus.div_divisor, bus.hi_out, bus.lo_out,
           bus.busy, bus.done, bus.div_tvalid} !== '0)
         $display("FAIL reset_outputs: got nonzero outputs hi=%h lo=%h busy=%b done=%b, exp all 0",
                  bus.hi_out, bus.lo_out, bus.busy, bus.done);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_cnt++;
      if (dbg_state !== S_IDLE || bus.busy !== 1'b0)
         $display("FAIL reset_idle: got state=%0d busy=%b, exp 0/0", dbg_state, bus.busy);
      else pass_cnt++;
   endtask

   task automatic test_mul_directed;
      int lat;
      run_op(1'b0, 1'b0, 32'hFFFF_FFFE, 32'd3, lat);
      check_cnt++;
      if (lat !== MUL_LAT + 1) $display("FAIL mult_latency: got %0d exp %0d", lat, MUL_LAT + 1);
      else pass_cnt++;
      check_cnt++;
      if ({bus.hi_out, bus.lo_out} !== 64'hFFFF_FFFF_FFFF_FFFA)
         $display("FAIL mult_neg_hilo: got %h_%h exp ffffffff_fffffffa", bus.hi_out, bus.lo_out);
      else pass_cnt++;
      ack_op();
      run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, lat);
      check_cnt++;
      if ({bus.hi_out, bus.lo_out} !== 64'h0000_0001_FFFF_FFFE)
         $display("FAIL multu_hilo: got %h_%h exp 00000001_fffffffe", bus.hi_out, bus.lo_out);
      else pass_cnt++;
      check_cnt++;
      if (bus.mul_a !== 33'h0_FFFF_FFFF)
         $display("FAIL multu_zext: got mul_a=%h exp 0ffffffff", bus.mul_a);
      else pass_cnt++;
      ack_op();
   endtask

   task automatic test_div_directed;
      int lat, t0, c0;
      div_lat = 20;
      t0 = tvalid_cnt;
      c0 = cyc;
      run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, lat);
      check_cnt++;
      if (cyc !== dv_cyc + 1 || tv_cyc !== c0 + 1 || dv_cyc !== tv_cyc + 20)
         $display("FAIL div_timing: got tvalid@%0d dout@%0d done@%0d, exp %0d/%0d/%0d",
                  tv_cyc, dv_cyc, cyc, c0 + 1, c0 + 21, c0 + 22);
      else pass_cnt++;
      check_cnt++;
      if ({bus.hi_out, bus.lo_out} !== 64'hFFFF_FFFF_FFFF_FFFD)
         $display("FAIL div_neg_hilo: got %h_%h exp ffffffff_fffffffd", bus.hi_out, bus.lo_out);
      else pass_cnt++;
      check_cnt++;
      if (bus.div_dividend !== 33'h1_FFFF_FFF9)
         $display("FAIL div_sext: got dividend=%h exp 1fffffff9", bus.div_dividend);
      else pass_cnt++;
      ack_op();
      check_cnt++;
      if (tvalid_cnt - t0 !== 1) $display("FAIL div_one_pulse: got %0d pulses exp 1", tvalid_cnt - t0);
      else pass_cnt++;
   endtask

   task automatic test_div_flush_drain;
      int c0, t0, drain_end, bad;
      logic [63:0] exp;
      div_lat = 15;
      t0 = tvalid_cnt;
      c0 = cyc;
      drive_op(1'b1, 1'b1, 32'd100, 32'd7);
      wait_cyc(c0 + 6);
      bus.flush = 1'b1;
      clear_req();
      #1;
      check_cnt++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1)
         $display("FAIL drain_flush_cycle: got done=%b busy=%b exp 0/1", bus.done, bus.busy);
      else pass_cnt++;
      @(negedge clk);
      bus.flush = 1'b0;
      drive_op(1'b0, 1'b0, 32'h0001_2345, 32'hFFFF_FFFF);
      exp = ref_result(1'b0, 1'b0, 32'h0001_2345, 32'hFFFF_FFFF);
      drain_end = c0 + 1 + div_lat;
      bad = 0;
      while (cyc <= drain_end) begin
         if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
         @(negedge clk);
      end
      check_cnt++;
      if (bad !== 0) $display("FAIL drain_busy_hold: got %0d bad cycles exp 0", bad);
      else pass_cnt++;
      check_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL drain_exit_idle: got busy=%b exp 0", bus.busy);
      else pass_cnt++;
      @(negedge clk);
      check_cnt++;
      if (bus.busy !== 1'b1 || bus.mul_a !== 33'h0_0001_2345)
         $display("FAIL drain_mult_start: got busy=%b mul_a=%h exp 1/000012345", bus.busy, bus.mul_a);
      else pass_cnt++;
      while (bus.done !== 1'b1 && cyc < drain_end + 50) @(negedge clk);
      check_cnt++;
      if (cyc !== drain_end + 2 + MUL_LAT || {bus.hi_out, bus.lo_out} !== exp)
         $display("FAIL drain_mult_result: got done@%0d %h_%h exp done@%0d %h",
                  cyc, bus.hi_out, bus.lo_out, drain_end + 2 + MUL_LAT, exp);
      else pass_cnt++;
      check_cnt++;
      if (tvalid_cnt - t0 !== 1 || dv_cyc !== drain_end)
         $display("FAIL drain_ip: got pulses=%0d dout@%0d exp 1/%0d", tvalid_cnt - t0, dv_cyc, drain_end);
      else pass_cnt++;
      ack_op();
   endtask

   task automatic test_done_hold;
      int lat;
      logic [63:0] exp;
      exp = ref_result(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_1234);
      run_op(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_1234, lat);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_cnt++;
         if (bus.done !== 1'b1 || {bus.hi_out, bus.lo_out} !== exp)
            $display("FAIL done_hold_%0d: got done=%b %h_%h exp 1 %h", i, bus.done,
                     bus.hi_out, bus.lo_out, exp);
         else pass_cnt++;
      end
      ack_op();
      check_cnt++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0)
         $display("FAIL done_after_ack: got done=%b busy=%b exp 0/0", bus.done, bus.busy);
      else pass_cnt++;
   endtask

   task automatic test_flush_cases;
      int lat, c0, t0;
      // flush while in MUL_WAIT
      drive_op(1'b0, 1'b0, 32'd5, 32'd6);
      @(negedge clk);
      bus.flush = 1'b1;
      clear_req();
      @(negedge clk);
      bus.flush = 1'b0;
      check_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL flush_mul_wait: got busy=%b exp 0", bus.busy);
      else pass_cnt++;
      // flush in DONE masks done in that same cycle
      run_op(1'b0, 1'b0, 32'd5, 32'd6, lat);
      bus.flush = 1'b1;
      #1;
      check_cnt++;
      if (bus.done !== 1'b0) $display("FAIL flush_done_mask: got done=%b exp 0", bus.done);
      else pass_cnt++;
      @(negedge clk);
      bus.flush = 1'b0;
      clear_req();
      check_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL flush_done_idle: got busy=%b exp 0", bus.busy);
      else pass_cnt++;
      // flush beats a request in IDLE
      drive_op(1'b1, 1'b0, 32'd9, 32'd3);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      clear_req();
      check_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL flush_beats_req: got busy=%b exp 0", bus.busy);
      else pass_cnt++;
      // flush in DIV_ISSUE still issues the pulse, then drains
      div_lat = 6;
      t0 = tvalid_cnt;
      c0 = cyc;
      drive_op(1'b1, 1'b0, 32'd50, 32'd5);
      @(negedge clk);
      bus.flush = 1'b1;
      clear_req();
      @(negedge clk);
      bus.flush = 1'b0;
      wait_cyc(c0 + 1 + div_lat);
      check_cnt++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0)
         $display("FAIL flush_issue_drain: got busy=%b done=%b exp 1/0", bus.busy, bus.done);
      else pass_cnt++;
      @(negedge clk);
      check_cnt++;
      if (bus.busy !== 1'b0 || tvalid_cnt - t0 !== 1)
         $display("FAIL flush_issue_end: got busy=%b pulses=%0d exp 0/1", bus.busy, tvalid_cnt - t0);
      else pass_cnt++;
      // flush coincident with div_dout_valid discards the result
      c0 = cyc;
      drive_op(1'b1, 1'b0, 32'd77, 32'd7);
      wait_cyc(c0 + 1 + div_lat);
      bus.flush = 1'b1;
      clear_req();
      @(negedge clk);
      bus.flush = 1'b0;
      check_cnt++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0)
         $display("FAIL flush_with_dout: got busy=%b done=%b exp 0/0", bus.busy, bus.done);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      int lat, bad;
      bit is_div, uns;
      logic [31:0] a, b;
      logic [31:0] corner [4];
      logic [63:0] exp;
      corner[0] = 32'h8000_0000;
      corner[1] = 32'hFFFF_FFFF;
      corner[2] = 32'h0000_0000;
      corner[3] = 32'h0000_0001;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         is_div = 1'($urandom_range(0, 1));
         uns    = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         if (is_div && b == 32'd0) b = 32'd3;
         div_lat = $urandom_range(1, 8);
         exp = ref_result(is_div, uns, a, b);
         run_op(is_div, uns, a, b, lat);
         check_cnt++;
         if (lat !== (is_div ? div_lat + 2 : MUL_LAT + 1) || {bus.hi_out, bus.lo_out} !== exp)
            $display("FAIL rand_op_%0d: got lat=%0d %h_%h exp lat=%0d %h (div=%0d uns=%0d a=%h b=%h)",
                     i, lat, bus.hi_out, bus.lo_out, is_div ? div_lat + 2 : MUL_LAT + 1, exp,
                     is_div, uns, a, b);
         else pass_cnt++;
         ack_op();
         if (bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
      end
      check_cnt++;
      if (bad !== 0) $display("FAIL no_restart_on_ack: got %0d restarts exp 0", bad);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_op;
      drive_op(1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_cnt++;
      if ({bus.mul_a, bus.mul_b, bus.div_dividend, bus.div_divisor, bus.hi_out, bus.lo_out,
           bus.busy, bus.done, bus.div_tvalid} !== '0)
         $display("FAIL reset_async: got hi=%h lo=%h mul_a=%h busy=%b exp all 0",
                  bus.hi_out, bus.lo_out, bus.mul_a, bus.busy);
      else pass_cnt++;
      clear_req();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_cnt++;
      if (dbg_state !== S_IDLE || bus.busy !== 1'b0 || bus.done !== 1'b0)
         $display("FAIL reset_release_idle: got state=%0d busy=%b done=%b exp 0/0/0",
                  dbg_state, bus.busy, bus.done);
      else pass_cnt++;
   endtask

   initial begin
      reset = 1'b1;
      bus.exe_valid   = 1'b0;
      bus.mul_req     = 1'b0;
      bus.div_req     = 1'b0;
      bus.unsigned_op = 1'b0;
      bus.op_a        = '0;
      bus.op_b        = '0;
      bus.exe_ack     = 1'b0;
      bus.flush       = 1'b0;
      @(negedge clk);
      test_reset();
      test_mul_directed();
      test_div_directed();
      test_div_flush_drain();
      test_done_hold();
      test_flush_cases();
      test_back_to_back();
      test_reset_mid_op();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", pass_cnt, check_cnt);
      $fatal(1);
   end

endmodule
